// File: rtl/alu_operand_sequencer.sv
// Command sequencer around an external 32-bit combinational ALU: register file, operand staging, result capture and writeback.
// Latency: accept at T, result captured/written at T+1, res_valid after T+1; cmd_ready only in IDLE, result held until res_ready.
module alu_operand_sequencer #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [2:0]    cmd_f,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [31:0]   cmd_imm,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [2:0]    alu_f,
  input  logic [31:0]   alu_y,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_y,
  output logic          res_zero,
  output logic [AW-1:0] res_rd,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic          accept_ld, accept_op, exec_done;
  logic [31:0]   rf [NREGS];
  logic [31:0]   rs1_val, rs2_val;
  logic [AW-1:0] rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    accept_ld = 1'b0;
    accept_op = 1'b0;
    exec_done = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          if (cmd_ld) begin
            accept_ld = 1'b1;
          end else begin
            accept_op = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // r0 is never written, but the read path forces zero regardless
  assign rs1_val = (cmd_rs1 == '0) ? '0 : rf[cmd_rs1];
  assign rs2_val = (cmd_rs2 == '0) ? '0 : rf[cmd_rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      if (accept_ld && cmd_rd != '0) rf[cmd_rd] <= cmd_imm;
      if (exec_done && rd_q != '0)   rf[rd_q]   <= alu_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_f    <= '0;
      rd_q     <= '0;
      res_y    <= '0;
      res_zero <= 1'b0;
      res_rd   <= '0;
      op_count <= '0;
    end else begin
      if (accept_op) begin
        alu_a <= rs1_val;
        alu_b <= rs2_val;
        alu_f <= cmd_f;
        rd_q  <= cmd_rd;
      end
      if (exec_done) begin
        res_y    <= alu_y;
        res_zero <= alu_zero;
        res_rd   <= rd_q;
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule
